// File: rtl/uart_deser_par.sv
// ---------------------------------------------------------------------------
// uart_deser_par
//
// UART frame deserializer with optional parity. It sits behind an oversampling
// front end that has already located the start bit and majority-voted each
// bit cell. It assembles data bits into a word, checks parity and the stop
// bit, and presents the result with a valid/ack handshake.
//
// Parameters
//   DATA_WIDTH : data bits per frame (5..9)
//   MSB_FIRST  : 0 = first received bit lands in P_DATA[0],
//                1 = first received bit lands in P_DATA[DATA_WIDTH-1]
//   PAR_EN     : 1 = one parity bit follows the data bits
//   PAR_TYPE   : 0 = even parity, 1 = odd parity
//
// Ports
//   CLK         in   rising-edge clock (single clock domain)
//   RST         in   synchronous active-high reset
//   start       in   start bit accepted by the sampler (1-cycle pulse)
//   bit_strb    in   sampled_bit is valid this cycle (1-cycle pulse)
//   sampled_bit in   majority-sampled line value
//   abort       in   discard the frame in progress
//   data_ack    in   consumer has taken P_DATA
//   P_DATA      out  last completed frame data
//   data_valid  out  P_DATA holds unacknowledged data
//   par_err     out  parity mismatch on the frame in P_DATA
//   stp_err     out  stop bit was 0 on the frame in P_DATA
//   overrun     out  1-cycle pulse: a completed frame was dropped
//   busy        out  high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_deser_par #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  bit_strb,
  input  logic                  sampled_bit,
  input  logic                  abort,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  // Four bits comfortably count up to the largest legal DATA_WIDTH (9).
  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic              PAR_ODD  = (PAR_TYPE != 0);
  localparam logic              HAS_PAR  = (PAR_EN != 0);
  localparam logic              MSB_FST  = (MSB_FIRST != 0);

  // Parity error: the XOR over data plus received parity bit must equal the
  // selected parity sense (0 for even, 1 for odd).
  function automatic logic parity_err(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  par_bit,
                                      input logic                  odd);
    return (((^data) ^ par_bit) != odd);
  endfunction

  // Insert one received bit. LSB-first frames enter at the MSB and move
  // right so the first bit ends at bit 0; MSB-first frames do the mirror.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic                  b,
                                                     input logic                  msb_first);
    logic [DATA_WIDTH-1:0] res;
    if (msb_first) begin
      res = {sr[DATA_WIDTH-2:0], b};
    end else begin
      res = {b, sr[DATA_WIDTH-1:1]};
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  complete_s;

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    par_flag_d   = par_flag_q;
    p_data_d     = p_data_q;
    data_valid_d = data_valid_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    overrun_d    = 1'b0;
    complete_s   = 1'b0;

    case (state_q)
      IDLE: begin
        // A strobe coinciding with start belongs to the start bit, not data.
        if (start) begin
          state_d    = DATA;
          cnt_d      = CNT_ZERO;
          sr_d       = DATA_ZERO;
          par_flag_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bit_strb) begin
          sr_d = shift_in(sr_q, sampled_bit, MSB_FST);
          if (cnt_q == LAST_CNT) begin
            cnt_d   = CNT_ZERO;
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      PAR: begin
        if (bit_strb) begin
          par_flag_d = parity_err(sr_q, sampled_bit, PAR_ODD);
          state_d    = STOP;
        end else begin
          state_d = PAR;
        end
      end
      STOP: begin
        if (bit_strb) begin
          complete_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over start/strobe; the published result is left alone.
    if (abort) begin
      state_d    = IDLE;
      complete_s = 1'b0;
    end else begin
      complete_s = complete_s;
    end

    // A completed frame is published only if the output slot is free or is
    // being freed this very cycle; otherwise it is dropped and flagged.
    if (complete_s) begin
      if (!data_valid_q || data_ack) begin
        p_data_d     = sr_q;
        par_err_d    = par_flag_q;
        stp_err_d    = !sampled_bit;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_ack && data_valid_q) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      sr_q         <= DATA_ZERO;
      par_flag_q   <= 1'b0;
      p_data_q     <= DATA_ZERO;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      par_flag_q   <= par_flag_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_deser_par.sv
// ---------------------------------------------------------------------------
// tb_uart_deser_par
//
// Two instances share one stimulus stream: u0 uses the defaults (LSB-first,
// even parity) and u1 is MSB-first with odd parity. A frame-level model keeps
// the received bits of each instance in a list and derives the published
// word, parity and stop flags from that list at completion. A negedge
// process compares every output of both instances against the model each
// cycle; literal checks pin the model on the reference frames.
// ---------------------------------------------------------------------------
module tb_uart_deser_par;

  logic CLK = 1'b0;
  logic rst_i = 1'b0, start_i = 1'b0, strb_i = 1'b0, sbit_i = 1'b0;
  logic abort_i = 1'b0, ack_i = 1'b0;

  logic [7:0] pd0, pd1;
  logic [1:0] dv, pe, se, ov, bz;

  always #5 CLK = ~CLK;

  uart_deser_par #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_EN(1), .PAR_TYPE(0)) u0 (
    .CLK(CLK), .RST(rst_i), .start(start_i), .bit_strb(strb_i),
    .sampled_bit(sbit_i), .abort(abort_i), .data_ack(ack_i),
    .P_DATA(pd0), .data_valid(dv[0]), .par_err(pe[0]), .stp_err(se[0]),
    .overrun(ov[0]), .busy(bz[0]));

  uart_deser_par #(.DATA_WIDTH(8), .MSB_FIRST(1), .PAR_EN(1), .PAR_TYPE(1)) u1 (
    .CLK(CLK), .RST(rst_i), .start(start_i), .bit_strb(strb_i),
    .sampled_bit(sbit_i), .abort(abort_i), .data_ack(ack_i),
    .P_DATA(pd1), .data_valid(dv[1]), .par_err(pe[1]), .stp_err(se[1]),
    .overrun(ov[1]), .busy(bz[1]));

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Frame-level model state per instance.
  logic       m_in     [2];
  int         m_n      [2];
  logic [8:0] m_bits   [2];
  logic       m_gotpar [2];
  logic       m_pbit   [2];
  // Expected outputs (visible now) and their values after the next edge.
  logic [7:0] exp_p [2], nxt_p [2];
  logic       exp_dv[2], nxt_dv[2];
  logic       exp_pe[2], nxt_pe[2];
  logic       exp_se[2], nxt_se[2];
  logic       exp_ov[2], nxt_ov[2];
  logic       exp_bz[2], nxt_bz[2];

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d at %0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Advance the model of instance k across one clock edge.
  task automatic model_edge(input int k, input logic st, input logic bs, input logic sb,
                            input logic ab, input logic ack, input logic rs);
    logic       msb, odd, done, stop_b;
    logic [7:0] val;
    int         ones;
    msb = (k == 1);
    odd = (k == 1);
    done = 1'b0;
    stop_b = 1'b0;
    val = 8'h00;
    nxt_p[k] = exp_p[k]; nxt_dv[k] = exp_dv[k]; nxt_pe[k] = exp_pe[k];
    nxt_se[k] = exp_se[k]; nxt_ov[k] = 1'b0; nxt_bz[k] = exp_bz[k];
    if (rs) begin
      m_in[k] = 1'b0; m_n[k] = 0; m_gotpar[k] = 1'b0;
      nxt_p[k] = 8'h00; nxt_dv[k] = 1'b0; nxt_pe[k] = 1'b0;
      nxt_se[k] = 1'b0; nxt_bz[k] = 1'b0;
    end else begin
      if (ab) begin
        m_in[k] = 1'b0;
      end else if (!m_in[k]) begin
        if (st) begin
          m_in[k] = 1'b1; m_n[k] = 0; m_gotpar[k] = 1'b0;
        end
      end else if (bs) begin
        if (m_n[k] < 8) begin
          m_bits[k][m_n[k]] = sb;
          m_n[k]++;
        end else if (!m_gotpar[k]) begin
          m_gotpar[k] = 1'b1;
          m_pbit[k] = sb;
        end else begin
          done = 1'b1;
          stop_b = sb;
          m_in[k] = 1'b0;
        end
      end
      if (done) begin
        ones = 0;
        for (int i = 0; i < 8; i++) begin
          ones += int'(m_bits[k][i]);
          val[msb ? 7 - i : i] = m_bits[k][i];
        end
        if (!exp_dv[k] || ack) begin
          nxt_p[k]  = val;
          nxt_pe[k] = (((ones + int'(m_pbit[k])) % 2) == 1) != odd;
          nxt_se[k] = !stop_b;
          nxt_dv[k] = 1'b1;
        end else begin
          nxt_ov[k] = 1'b1;
        end
      end else if (ack && exp_dv[k]) begin
        nxt_dv[k] = 1'b0;
      end
      nxt_bz[k] = m_in[k];
    end
  endtask

  task automatic step(input logic st, input logic bs, input logic sb,
                      input logic ab, input logic ack, input logic rs);
    start_i = st; strb_i = bs; sbit_i = sb; abort_i = ab; ack_i = ack; rst_i = rs;
    model_edge(0, st, bs, sb, ab, ack, rs);
    model_edge(1, st, bs, sb, ab, ack, rs);
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      exp_p[k] = nxt_p[k]; exp_dv[k] = nxt_dv[k]; exp_pe[k] = nxt_pe[k];
      exp_se[k] = nxt_se[k]; exp_ov[k] = nxt_ov[k]; exp_bz[k] = nxt_bz[k];
    end
    #1;
  endtask

  // b[0] is the first data bit on the line.
  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop,
                            input logic ack_last, input logic strb_with_start);
    step(1'b1, strb_with_start, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, b[i], 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, pbit, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, stop, 1'b0, ack_last, 1'b0);
  endtask

  task automatic idle_ack();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("p_data", 0, pd0, exp_p[0]);
      check("p_data", 1, pd1, exp_p[1]);
      for (int k = 0; k < 2; k++) begin
        check("data_valid", k, {7'd0, dv[k]}, {7'd0, exp_dv[k]});
        check("par_err",    k, {7'd0, pe[k]}, {7'd0, exp_pe[k]});
        check("stp_err",    k, {7'd0, se[k]}, {7'd0, exp_se[k]});
        check("overrun",    k, {7'd0, ov[k]}, {7'd0, exp_ov[k]});
        check("busy",       k, {7'd0, bz[k]}, {7'd0, exp_bz[k]});
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 1'b0; m_n[k] = 0; m_bits[k] = 9'd0; m_gotpar[k] = 1'b0; m_pbit[k] = 1'b0;
      exp_p[k] = 8'h00; exp_dv[k] = 1'b0; exp_pe[k] = 1'b0;
      exp_se[k] = 1'b0; exp_ov[k] = 1'b0; exp_bz[k] = 1'b0;
    end

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_p_data", 0, pd0, 8'h00);
    check("rst_valid",  0, {7'd0, dv[0]}, 8'h00);
    check("rst_busy",   0, {7'd0, bz[0]}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_strobe_busy", 0, {7'd0, bz[0]}, 8'h00);

    // Reference frame 0xA5, good parity and stop
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("a5_data",   0, pd0, 8'hA5);
    check("a5_valid",  0, {7'd0, dv[0]}, 8'h01);
    check("a5_par",    0, {7'd0, pe[0]}, 8'h00);
    check("a5_stp",    0, {7'd0, se[0]}, 8'h00);
    idle_ack();
    check("ack_clears", 0, {7'd0, dv[0]}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Parity bit wrong
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("a5_perr_data", 0, pd0, 8'hA5);
    check("a5_perr",      0, {7'd0, pe[0]}, 8'h01);
    idle_ack();

    // Stop bit 0
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_serr",       0, {7'd0, se[0]}, 8'h01);
    check("a5_serr_valid", 0, {7'd0, dv[0]}, 8'h01);
    idle_ack();

    // MSB-first odd-parity reference on u1
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    check("3c_data", 1, pd1, 8'h3C);
    check("3c_par",  1, {7'd0, pe[1]}, 8'h00);
    idle_ack();

    // Back-to-back frames without ack: second is dropped
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 0, {7'd0, ov[0]}, 8'h01);
    check("ovr_keep",  0, pd0, 8'h11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_one_cycle", 0, {7'd0, ov[0]}, 8'h00);
    // Ack on the completing cycle lets the new frame in
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ack_same_data",  0, pd0, 8'h22);
    check("ack_same_valid", 0, {7'd0, dv[0]}, 8'h01);
    check("ack_same_ovr",   0, {7'd0, ov[0]}, 8'h00);
    idle_ack();

    // Abort after 4 data bits, then a full 0x5A frame (strobe with start)
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_busy",  0, {7'd0, bz[0]}, 8'h00);
    check("abort_valid", 0, {7'd0, dv[0]}, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    check("5a_data",  0, pd0, 8'h5A);
    check("5a_valid", 0, {7'd0, dv[0]}, 8'h01);

    // Reset after 3 data bits
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst_data",  0, pd0, 8'h00);
    check("mid_rst_valid", 0, {7'd0, dv[0]}, 8'h00);
    check("mid_rst_busy",  0, {7'd0, bz[0]}, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_no_valid", 0, {7'd0, dv[0]}, 8'h00);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
